// File: rtl/fifo_rd_arbiter.sv
// Round-robin read scheduler for the FIFO read port: grants bounded read bursts to one of
// NUM_REQ consumers and sequences flush requests into the rd_enable+flush pair.
module fifo_rd_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                r_clk,
   input  logic                rresetn,
   input  logic [NUM_REQ-1:0]  req,
   input  logic                fifo_empty,
   input  logic                flush_req,
   output logic                rd_enable,
   output logic                flush,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] grant_id,
   output logic                flush_ack
);

   localparam int unsigned CntWidth = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {StIdle, StBurst, StFlush, StFlushAck} state_e;

   state_e                state_q, state_d;
   logic [NUM_REQ-1:0]    grant_q, grant_d;
   logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
   logic [CntWidth-1:0]   beat_cnt_q, beat_cnt_d;
   logic [ID_WIDTH-1:0]   last_winner_q, last_winner_d;

   logic [2*NUM_REQ-1:0]  req_rot;
   logic                  win_found;
   logic [ID_WIDTH-1:0]   win_id;
   int unsigned           win_sum;
   logic                  req_granted;

   // Rotating a doubled request vector puts requester (last_winner+1) at bit 0.
   always_comb begin
      req_rot   = {req, req} >> (32'(last_winner_q) + 32'd1);
      win_found = 1'b0;
      win_id    = '0;
      win_sum   = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!win_found && req_rot[i]) begin
            win_found = 1'b1;
            win_sum   = 32'(last_winner_q) + 32'd1 + i;
            if (win_sum >= NUM_REQ) begin
               win_sum = win_sum - NUM_REQ;
            end
            win_id = ID_WIDTH'(win_sum);
         end
      end
   end

   // grant_q is one-hot, so this selects req[grant_id_q] without an index-width mismatch.
   assign req_granted = |(req & grant_q);

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      grant_id_d    = grant_id_q;
      beat_cnt_d    = beat_cnt_q;
      last_winner_d = last_winner_q;
      rd_enable     = 1'b0;
      flush         = 1'b0;
      flush_ack     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (flush_req) begin
               state_d = StFlush;
            end else if (win_found && !fifo_empty) begin
               grant_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
               grant_id_d    = win_id;
               last_winner_d = win_id;
               beat_cnt_d    = '0;
               state_d       = StBurst;
            end
         end
         StBurst: begin
            rd_enable = req_granted & ~fifo_empty & ~flush_req;
            if (flush_req) begin
               grant_d    = '0;
               grant_id_d = '0;
               state_d    = StFlush;
            end else if (!req_granted) begin
               grant_d    = '0;
               grant_id_d = '0;
               state_d    = StIdle;
            end else if (!fifo_empty) begin
               beat_cnt_d = beat_cnt_q + CntWidth'(1);
               if (beat_cnt_q == CntWidth'(MAX_BURST - 1)) begin
                  grant_d    = '0;
                  grant_id_d = '0;
                  state_d    = StIdle;
               end
            end
         end
         StFlush: begin
            rd_enable = 1'b1;
            flush     = 1'b1;
            state_d   = StFlushAck;
         end
         StFlushAck: begin
            flush_ack = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge r_clk or negedge rresetn) begin
      if (!rresetn) begin
         state_q       <= StIdle;
         grant_q       <= '0;
         grant_id_q    <= '0;
         beat_cnt_q    <= '0;
         last_winner_q <= ID_WIDTH'(NUM_REQ - 1);
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         grant_id_q    <= grant_id_d;
         beat_cnt_q    <= beat_cnt_d;
         last_winner_q <= last_winner_d;
      end
   end

   assign grant    = grant_q;
   assign grant_id = grant_id_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: a cycle-by-cycle vector table plus hand-written
// sequences for mid-burst stall and asynchronous reset during a burst.
module tb_fifo_rd_arbiter;

   logic       r_clk = 1'b0;
   logic       rresetn;
   logic [3:0] req;
   logic       fifo_empty;
   logic       flush_req;
   logic       rd_enable;
   logic       flush;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       flush_ack;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] req;
      logic       empty;
      logic       frq;
      logic       rd;
      logic       fl;
      logic [3:0] g;
      logic [1:0] id;
      logic       ack;
   } vec_t;

   vec_t vecs[$];

   fifo_rd_arbiter #(
      .NUM_REQ   (4),
      .MAX_BURST (4)
   ) dut (
      .r_clk      (r_clk),
      .rresetn    (rresetn),
      .req        (req),
      .fifo_empty (fifo_empty),
      .flush_req  (flush_req),
      .rd_enable  (rd_enable),
      .flush      (flush),
      .grant      (grant),
      .grant_id   (grant_id),
      .flush_ack  (flush_ack)
   );

   always #5 r_clk = ~r_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] r, input logic e, input logic f, input logic rd,
                      input logic fl, input logic [3:0] g, input logic [1:0] id,
                      input logic ack);
      vec_t v;
      v.req = r; v.empty = e; v.frq = f; v.rd = rd; v.fl = fl; v.g = g; v.id = id; v.ack = ack;
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge r_clk);
      @(negedge r_clk);
   endtask

   initial begin
      int beats;
      int guard;

      rresetn = 1'b0; req = '0; fifo_empty = 1'b0; flush_req = 1'b0;

      //  req    emp frq  rd fl grant   id  ack
      // single requester: 4 beats, 1 idle cycle, repeat
      add(4'b0001, 0, 0,  0, 0, 4'b0000, 0, 0);
      repeat (4) add(4'b0001, 0, 0, 1, 0, 4'b0001, 0, 0);
      add(4'b0001, 0, 0,  0, 0, 4'b0000, 0, 0);
      repeat (4) add(4'b0001, 0, 0, 1, 0, 4'b0001, 0, 0);
      // all requesting: order 1,2,3,0 after requester 0 won last
      add(4'b1111, 0, 0,  0, 0, 4'b0000, 0, 0);
      repeat (4) add(4'b1111, 0, 0, 1, 0, 4'b0010, 1, 0);
      add(4'b1111, 0, 0,  0, 0, 4'b0000, 0, 0);
      repeat (4) add(4'b1111, 0, 0, 1, 0, 4'b0100, 2, 0);
      add(4'b1111, 0, 0,  0, 0, 4'b0000, 0, 0);
      repeat (4) add(4'b1111, 0, 0, 1, 0, 4'b1000, 3, 0);
      add(4'b1111, 0, 0,  0, 0, 4'b0000, 0, 0);
      add(4'b1111, 0, 0,  1, 0, 4'b0001, 0, 0);
      // grantee drops req: no beat, back to idle
      add(4'b0000, 0, 0,  0, 0, 4'b0001, 0, 0);
      add(4'b0000, 0, 0,  0, 0, 4'b0000, 0, 0);
      // flush preempting beat 2 of a burst to requester 2
      add(4'b0100, 0, 0,  0, 0, 4'b0000, 0, 0);
      add(4'b0100, 0, 0,  1, 0, 4'b0100, 2, 0);
      add(4'b0100, 0, 1,  0, 0, 4'b0100, 2, 0);
      add(4'b0100, 1, 1,  1, 1, 4'b0000, 0, 0);
      add(4'b0100, 0, 1,  0, 0, 4'b0000, 0, 1);
      add(4'b0100, 0, 0,  0, 0, 4'b0000, 0, 0);
      add(4'b0100, 0, 0,  1, 0, 4'b0100, 2, 0);
      add(4'b0000, 0, 0,  0, 0, 4'b0100, 2, 0);
      // req and flush_req together in idle: flush first
      add(4'b0010, 0, 1,  0, 0, 4'b0000, 0, 0);
      add(4'b0010, 0, 1,  1, 1, 4'b0000, 0, 0);
      add(4'b0010, 0, 1,  0, 0, 4'b0000, 0, 1);
      add(4'b0010, 0, 0,  0, 0, 4'b0000, 0, 0);
      add(4'b0010, 0, 0,  1, 0, 4'b0010, 1, 0);
      add(4'b0000, 0, 0,  0, 0, 4'b0010, 1, 0);
      add(4'b0000, 0, 0,  0, 0, 4'b0000, 0, 0);

      repeat (2) @(negedge r_clk);
      chk("reset rd_enable", 32'(rd_enable), 0);
      chk("reset flush", 32'(flush), 0);
      chk("reset grant", 32'(grant), 0);
      chk("reset grant_id", 32'(grant_id), 0);
      chk("reset flush_ack", 32'(flush_ack), 0);
      rresetn = 1'b1;

      foreach (vecs[i]) begin
         req = vecs[i].req; fifo_empty = vecs[i].empty; flush_req = vecs[i].frq;
         #1;
         chk($sformatf("v%0d rd_enable", i), 32'(rd_enable), 32'(vecs[i].rd));
         chk($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].fl));
         chk($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].g));
         chk($sformatf("v%0d grant_id", i), 32'(grant_id), 32'(vecs[i].id));
         chk($sformatf("v%0d flush_ack", i), 32'(flush_ack), 32'(vecs[i].ack));
         tick();
      end

      // Stall: requester 2 granted, FIFO empty for 3 cycles after the first beat.
      req = 4'b0100; fifo_empty = 1'b0; flush_req = 1'b0;
      tick();
      #1;
      chk("stall first beat", 32'(rd_enable), 1);
      beats = 1;
      tick();
      fifo_empty = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("stall%0d rd_enable", k), 32'(rd_enable), 0);
         chk($sformatf("stall%0d grant_id", k), 32'(grant_id), 2);
         tick();
      end
      fifo_empty = 1'b0;
      guard = 0;
      #1;
      while (grant != 4'b0000 && guard < 10) begin
         if (rd_enable) beats++;
         guard++;
         tick();
         #1;
      end
      chk("stall grant released", 32'(grant), 0);
      chk("stall total beats", 32'(beats), 4);
      req = 4'b0000;
      tick();

      // Async reset mid-burst; afterwards requester 0 has priority again.
      req = 4'b1111;
      tick();
      #1;
      chk("pre-reset grant", 32'(grant), 32'(4'b1000));
      tick();
      #2;
      rresetn = 1'b0;
      #1;
      chk("async reset grant", 32'(grant), 0);
      chk("async reset grant_id", 32'(grant_id), 0);
      chk("async reset rd_enable", 32'(rd_enable), 0);
      chk("async reset flush", 32'(flush), 0);
      @(negedge r_clk);
      rresetn = 1'b1;
      req = 4'b0110;
      #1;
      chk("post-reset idle grant", 32'(grant), 0);
      tick();
      #1;
      chk("post-reset grant", 32'(grant), 32'(4'b0010));
      chk("post-reset grant_id", 32'(grant_id), 1);
      chk("post-reset rd_enable", 32'(rd_enable), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
